// File: rtl/mouse_pos_filter.sv
// Per-frame mouse conditioning: latch raw position on vblnk rise, clamp to playfield,
// optionally slew-limit (define MOUSE_SLEW_EN), and debounce the left button into a click.
module mouse_pos_filter #(
  parameter int unsigned X_MIN           = 0,
  parameter int unsigned X_MAX           = 1023,
  parameter int unsigned Y_MIN           = 0,
  parameter int unsigned Y_MAX           = 767,
  parameter int unsigned MAX_STEP        = 16,
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos_raw,
  input  logic [11:0] ypos_raw,
  input  logic        left_raw,
  input  logic        vblnk,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        pos_valid,
  output logic        left_click
);

  localparam int unsigned W  = 12;
  localparam int unsigned CW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [W-1:0]  X_LO  = W'(X_MIN);
  localparam logic [W-1:0]  X_HI  = W'(X_MAX);
  localparam logic [W-1:0]  Y_LO  = W'(Y_MIN);
  localparam logic [W-1:0]  Y_HI  = W'(Y_MAX);
  localparam logic [W-1:0]  X_RST = W'((X_MIN + X_MAX) / 2);
  localparam logic [W-1:0]  Y_RST = W'((Y_MIN + Y_MAX) / 2);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_FRAMES);

  if (DEBOUNCE_FRAMES == 0) begin : g_bad_debounce
    $error("DEBOUNCE_FRAMES must be at least 1");
  end
  if (MAX_STEP == 0) begin : g_bad_step
    $error("MAX_STEP must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_CLAMP, S_UPDATE} state_t;

  state_t        state_q, state_d;
  logic          vblnk_q;
  logic          frame_tick_c;
  logic [W-1:0]  x_cap_q, x_cap_d, y_cap_q, y_cap_d;
  logic          left_cap_q, left_cap_d;
  logic [W-1:0]  tx_q, tx_d, ty_q, ty_d;
  logic [W-1:0]  xpos_q, xpos_d, ypos_q, ypos_d;
  logic          pos_valid_q, pos_valid_d;
  logic          left_click_q, left_click_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          armed_q, armed_d;

  function automatic logic [W-1:0] clamp(input logic [W-1:0] v, input logic [W-1:0] lo,
                                         input logic [W-1:0] hi);
    if (v <= lo)      return lo;
    else if (v >= hi) return hi;
    else              return v;
  endfunction

`ifdef MOUSE_SLEW_EN
  // Both cur and tgt lie inside the bounds, so a capped step can never leave them.
  function automatic logic [W-1:0] slew(input logic [W-1:0] cur, input logic [W-1:0] tgt);
    logic signed [W:0] d;
    logic signed [W:0] step;
    d    = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    step = $signed((W+1)'(MAX_STEP));
    if (d > step)       return W'(cur + W'(MAX_STEP));
    else if (d < -step) return W'(cur - W'(MAX_STEP));
    else                return tgt;
  endfunction
`endif

  assign frame_tick_c = vblnk & ~vblnk_q;

  always_comb begin
    state_d      = state_q;
    x_cap_d      = x_cap_q;
    y_cap_d      = y_cap_q;
    left_cap_d   = left_cap_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
    xpos_d       = xpos_q;
    ypos_d       = ypos_q;
    cnt_d        = cnt_q;
    armed_d      = armed_q;
    pos_valid_d  = 1'b0;
    left_click_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (frame_tick_c) begin
          x_cap_d    = xpos_raw;
          y_cap_d    = ypos_raw;
          left_cap_d = left_raw;
          state_d    = S_CLAMP;
        end
      end
      S_CLAMP: begin
        tx_d    = clamp(x_cap_q, X_LO, X_HI);
        ty_d    = clamp(y_cap_q, Y_LO, Y_HI);
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
`ifdef MOUSE_SLEW_EN
        xpos_d = slew(xpos_q, tx_q);
        ypos_d = slew(ypos_q, ty_q);
`else
        xpos_d = tx_q;
        ypos_d = ty_q;
`endif
        pos_valid_d = 1'b1;
        // Click fires once when the press run first reaches the threshold.
        if (!left_cap_q) begin
          cnt_d   = '0;
          armed_d = 1'b1;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
          if ((cnt_d == CNT_MAX) && armed_q) begin
            left_click_d = 1'b1;
            armed_d      = 1'b0;
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      vblnk_q      <= 1'b0;
      x_cap_q      <= '0;
      y_cap_q      <= '0;
      left_cap_q   <= 1'b0;
      tx_q         <= '0;
      ty_q         <= '0;
      xpos_q       <= X_RST;
      ypos_q       <= Y_RST;
      pos_valid_q  <= 1'b0;
      left_click_q <= 1'b0;
      cnt_q        <= '0;
      armed_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      vblnk_q      <= vblnk;
      x_cap_q      <= x_cap_d;
      y_cap_q      <= y_cap_d;
      left_cap_q   <= left_cap_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
      xpos_q       <= xpos_d;
      ypos_q       <= ypos_d;
      pos_valid_q  <= pos_valid_d;
      left_click_q <= left_click_d;
      cnt_q        <= cnt_d;
      armed_q      <= armed_d;
    end
  end

  assign xpos       = xpos_q;
  assign ypos       = ypos_q;
  assign pos_valid  = pos_valid_q;
  assign left_click = left_click_q;

endmodule
